// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - redirect, instruction-memory and decode-side signals of the fetch unit
interface fetch_unit_if #(
    parameter int N = 32
);
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [N-1:0] imem_rdata;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_instr;
    logic [N-1:0] out_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with PC-tagged instruction FIFO
// Optional macro FETCH_ALIGN_CHECK_EN adds the sticky misalign_err output.
module fetch_unit #(
    parameter int           N          = 32,
    parameter int           ADDR_BITS  = 20,
    parameter logic [N-1:0] RESET_PC   = '0,
    parameter int           FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic          misalign_err
`endif
);
    localparam int           PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int           CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [N-1:0] ADDR_MASK  = {{(N-ADDR_BITS){1'b0}}, {ADDR_BITS{1'b1}}};
    localparam logic [N-1:0] ALIGN_MASK = ADDR_MASK & {{(N-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t           state, state_next;
    logic [N-1:0]     pc;
    logic [N-1:0]     fifo_pc    [FIFO_DEPTH];
    logic [N-1:0]     fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_post_pop;
    logic             push, pop, issue;

    assign bus.out_valid = (count != '0);
    assign bus.out_instr = fifo_instr[rd_ptr];
    assign bus.out_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A redirect suppresses the pop and blocks new requests in the same cycle.
    always_comb begin
        state_next     = state;
        push           = 1'b0;
        issue          = 1'b0;
        pop            = bus.out_valid && bus.out_ready && !bus.redirect_valid;
        count_post_pop = count - CNT_W'(pop);
        case (state)
            IDLE: begin
                if (!bus.redirect_valid && (count_post_pop < DEPTH_C)) begin
                    issue      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.imem_ack) begin
                    push       = !bus.redirect_valid;
                    state_next = IDLE;
                end else if (bus.redirect_valid) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (bus.imem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC & ADDR_MASK;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_err  <= 1'b0;
`endif
        end else begin
            // The request cannot be withdrawn, so it stays up until acked even across redirects.
            if (issue) begin
                bus.imem_req  <= 1'b1;
                bus.imem_addr <= pc;
            end else if ((state != IDLE) && bus.imem_ack) begin
                bus.imem_req  <= 1'b0;
            end

            if (bus.redirect_valid) begin
                pc     <= bus.redirect_pc & ALIGN_MASK;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
                if (bus.redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
`endif
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr]    <= pc;
                    fifo_instr[wr_ptr] <= bus.imem_rdata;
                    wr_ptr             <= wr_ptr + PTR_W'(1);
                    pc                 <= (pc + N'(4)) & ADDR_MASK;
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end
endmodule
